// File: rtl/l2_wb_arbiter.sv
// l2_wb_arbiter: write-back arbiter for the L2. Two requesters (A = IF-side
// evictions, B = LSU-side evictions) each push into a private DEPTH-entry FIFO.
// A two-state FSM drains the FIFOs round-robin onto a registered main-memory
// write port, issuing back to back at one entry per cycle while mem_ready stays
// high. read_stop_en blocks new issues but never withdraws one already asserted.
//
// Optional feature: define L2_WB_FORWARD_EN to build the forwarding lookup
// (fwd_hit/fwd_data against queued and in-flight entries). Without it the
// forwarding outputs are tied to zero and no comparators exist.
//
// Ports (l2_wb_arbiter):
//   clk, reset                      clock, async active-high reset
//   a_valid/a_ready, a_addr/a_data  requester A push
//   b_valid/b_ready, b_addr/b_data  requester B push
//   read_stop_en                    memory read in progress, holds off issue
//   mem_start_write/mem_ready       memory write handshake
//   mem_adderss_write/mem_data_write registered write address/data
//   stop                            stall, either FIFO full
//   fwd_addr, fwd_hit/fwd_data      forwarding lookup

// Per-requester FIFO. Exposes the head and the entry behind it so the arbiter
// can reload the same requester on the accept edge without a bubble.
module l2_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [AW-1:0]           push_addr,
  input  logic [DW-1:0]           push_data,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic [AW-1:0]           head_addr,
  output logic [DW-1:0]           head_data,
  output logic [AW-1:0]           next_addr,
  output logic [DW-1:0]           next_data
`ifdef L2_WB_FORWARD_EN
  ,
  input  logic [AW-1:0]           fwd_addr,
  output logic                    fwd_hit,
  output logic [DW-1:0]           fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            rd_ptr, wr_ptr;

  assign full      = (count == CW'(DEPTH));
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign next_addr = addr_q[rd_ptr + PW'(1)];
  assign next_data = data_q[rd_ptr + PW'(1)];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef L2_WB_FORWARD_EN
  // Walk oldest to newest so the newest matching entry wins.
  logic [PW-1:0] idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
`endif
endmodule

module l2_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          read_stop_en,
  output logic          mem_start_write,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_adderss_write,
  output logic [DW-1:0] mem_data_write,
  output logic          stop,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data
);
  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("l2_wb_arbiter: DEPTH must be a power of two in 2..16");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Index 0 = requester A, index 1 = requester B.
  logic [1:0]           push, pop, full, ne, rem;
  logic [1:0][CW-1:0]   count;
  logic [1:0][AW-1:0]   in_addr, head_addr, next_addr;
  logic [1:0][DW-1:0]   in_data, head_data, next_data;

  state_t               state, state_nxt;
  logic                 prio, prio_nxt, sel, sel_nxt, pick;
  logic                 start_nxt;
  logic [AW-1:0]        addr_nxt;
  logic [DW-1:0]        data_nxt;

  assign a_ready = ~full[0];
  assign b_ready = ~full[1];
  assign stop    = |full;
  assign push    = {b_valid & ~full[1], a_valid & ~full[0]};
  assign in_addr = {b_addr, a_addr};
  assign in_data = {b_data, a_data};

  always_comb begin
    for (int i = 0; i < 2; i++) ne[i] = |count[i];
  end

`ifdef L2_WB_FORWARD_EN
  logic [1:0]         f_hit;
  logic [1:0][DW-1:0] f_data;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    l2_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .push_addr (in_addr[g]),
      .push_data (in_data[g]),
      .pop       (pop[g]),
      .count     (count[g]),
      .full      (full[g]),
      .head_addr (head_addr[g]),
      .head_data (head_data[g]),
      .next_addr (next_addr[g]),
      .next_data (next_data[g])
`ifdef L2_WB_FORWARD_EN
      ,
      .fwd_addr  (fwd_addr),
      .fwd_hit   (f_hit[g]),
      .fwd_data  (f_data[g])
`endif
    );
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    sel_nxt   = sel;
    start_nxt = mem_start_write;
    addr_nxt  = mem_adderss_write;
    data_nxt  = mem_data_write;
    pop       = '0;
    pick      = 1'b0;
    rem       = ne;
    case (state)
      IDLE: begin
        if (!read_stop_en && |ne) begin
          // Lone non-empty FIFO wins outright, otherwise prio breaks the tie.
          pick      = ne[1] & (~ne[0] | prio);
          sel_nxt   = pick;
          start_nxt = 1'b1;
          addr_nxt  = head_addr[pick];
          data_nxt  = head_data[pick];
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (mem_ready) begin
          pop[sel] = 1'b1;
          prio_nxt = ~sel;
          // Occupancy after this pop; pushes landing this edge are not yet readable.
          rem[sel] = |count[sel][CW-1:1];
          if (!read_stop_en && |rem) begin
            pick     = rem[1] & (~rem[0] | ~sel);
            sel_nxt  = pick;
            // Same requester again: its head is being popped, take the one behind.
            addr_nxt = (pick == sel) ? next_addr[pick] : head_addr[pick];
            data_nxt = (pick == sel) ? next_data[pick] : head_data[pick];
          end else begin
            start_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      prio              <= 1'b0;
      sel               <= 1'b0;
      mem_start_write   <= 1'b0;
      mem_adderss_write <= '0;
      mem_data_write    <= '0;
    end else begin
      state             <= state_nxt;
      prio              <= prio_nxt;
      sel               <= sel_nxt;
      mem_start_write   <= start_nxt;
      mem_adderss_write <= addr_nxt;
      mem_data_write    <= data_nxt;
    end
  end

`ifdef L2_WB_FORWARD_EN
  // Priority: in-flight entry, then newest B, then newest A.
  always_comb begin
    fwd_hit  = |f_hit;
    fwd_data = '0;
    if (f_hit[0]) fwd_data = f_data[0];
    if (f_hit[1]) fwd_data = f_data[1];
    if (mem_start_write && (mem_adderss_write == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = mem_data_write;
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif
endmodule

// File: doc/l2_wb_arbiter.md
L2_WB_ARBITER -- requirements
Module: l2_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving entries per requester FIFO; it SHALL be a power of two, 2..16.
REQ-002 The block SHALL have parameter AW, default 64, giving address width.
REQ-003 The block SHALL have parameter DW, default 64, giving data width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 a_valid/a_ready  in/out  1/1  requester A (IF-side evictions) push handshake.
REQ-007 a_addr/a_data  in  AW/DW  requester A write address and data.
REQ-008 b_valid/b_ready  in/out  1/1  requester B (LSU-side evictions) push handshake.
REQ-009 b_addr/b_data  in  AW/DW  requester B write address and data.
REQ-010 read_stop_en  in  1  main-memory read in progress; blocks new issues.
REQ-011 mem_start_write/mem_ready  out/in  1/1  main-memory write handshake.
REQ-012 mem_adderss_write/mem_data_write  out  AW/DW  registered write address and data.
REQ-013 stop  out  1  pipeline stall, high while either FIFO is full.
REQ-014 fwd_addr  in  AW  forwarding lookup address.
REQ-015 fwd_hit/fwd_data  out  1/DW  forwarding result.

Function
REQ-016 Each requester SHALL own a DEPTH-entry FIFO with wrapping read/write pointers and a count of width log2(DEPTH)+1.
REQ-017 A push SHALL occur on a cycle where x_valid and x_ready are both high; x_ready SHALL equal !full.
REQ-018 x_ready SHALL stay low when full, even if a pop occurs that cycle; there is no pass-through.
REQ-019 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-020 stop SHALL be combinational (fullA | fullB).
REQ-021 The FSM SHALL have two states: IDLE and SEND.
REQ-022 IDLE->SEND SHALL occur when !read_stop_en and either FIFO is non-empty; on that edge the selected head is registered onto the mem_* outputs and mem_start_write is set.
REQ-023 Selection SHALL be round-robin through a 1-bit priority register prio, where 0 prefers A and 1 prefers B.
REQ-024 If only one FIFO is non-empty, that FIFO SHALL be selected regardless of prio.
REQ-025 In SEND, mem_start_write, address and data SHALL hold stable until mem_ready is high; read_stop_en SHALL NOT withdraw an asserted request.
REQ-026 On the accept edge (SEND with mem_ready high), the block SHALL pop the selected FIFO and set prio to the opposite of the winner.
REQ-027 On that same edge, if !read_stop_en and an entry remains in either FIFO, the block SHALL reload the outputs and stay in SEND, giving back-to-back issues at 1 per cycle.
REQ-028 Otherwise, on the accept edge the block SHALL clear mem_start_write and go to IDLE.
REQ-029 Issue latency from a push into an empty, idle block SHALL be 1 cycle: mem_start_write is high the cycle after the push edge.
REQ-030 Entries within one FIFO SHALL issue in push order; no ordering is guaranteed between A and B.

Reset
REQ-031 While reset is high, the block SHALL clear both FIFO pointers and counts, set FSM=IDLE and prio=0, and drive mem_start_write=0, mem_adderss_write=0 and mem_data_write=0, all asynchronously.
REQ-032 Reset asserted in SEND SHALL drop mem_start_write immediately and discard the in-flight entry.
REQ-033 After reset, a_ready=1, b_ready=1, stop=0, fwd_hit=0 and fwd_data=0.

Configuration
REQ-034 With macro L2_WB_FORWARD_EN defined, fwd_hit SHALL be combinationally high when any valid FIFO entry, or the in-flight SEND entry, matches fwd_addr.
REQ-035 With L2_WB_FORWARD_EN defined, fwd_data SHALL be selected by priority: in-flight entry, then newest B entry, then newest A entry.
REQ-036 Without L2_WB_FORWARD_EN, fwd_hit and fwd_data SHALL be tied to 0 and no comparators SHALL be built.

Verification
REQ-037 Single-push test: push A (addr 0x100, data 0xAA) with mem_ready=1 -> next cycle mem_start_write=1, address 0x100, data 0xAA; cycle after, IDLE and mem_start_write=0.
REQ-038 Round-robin test: preload A0, A1, B0, B1 with read_stop_en=1, then release with mem_ready=1 -> issue order A0, B0, A1, B1 on 4 consecutive cycles.
REQ-039 Full and stall test: 4 pushes to A while mem_ready=0 -> a_ready=0 and stop=1; a fifth push is ignored; one accept -> a_ready=1 the following cycle.
REQ-040 Read-stop test: assert read_stop_en while in SEND with mem_ready=0 -> request and data hold; after accept, no new issue until read_stop_en=0.
REQ-041 Mid-operation reset test: pulse reset while in SEND with 3 entries queued -> mem_start_write=0 in the same cycle, both FIFOs empty, stop=0.
REQ-042 Forwarding test (L2_WB_FORWARD_EN): queue A (0x200, 0x11), then B (0x200, 0x22), and set fwd_addr=0x200 -> fwd_hit=1, fwd_data=0x22; without the macro -> fwd_hit=0.
